// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU and the result is captured and returned per requester.
module alu_share_arbiter #(
   parameter int DATA_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [1:0]              req_valid_in,
   output logic [1:0]              req_ready_out,
   input  logic [OPCODE_WIDTH-1:0] req0_opcode_in,
   input  logic [DATA_WIDTH-1:0]   req0_a_in,
   input  logic [DATA_WIDTH-1:0]   req0_b_in,
   input  logic [OPCODE_WIDTH-1:0] req1_opcode_in,
   input  logic [DATA_WIDTH-1:0]   req1_a_in,
   input  logic [DATA_WIDTH-1:0]   req1_b_in,
   output logic [1:0]              resp_valid_out,
   input  logic [1:0]              resp_ready_in,
   output logic [DATA_WIDTH:0]     resp_data_out,
   output logic [OPCODE_WIDTH-1:0] alu_opcode_out,
   output logic [DATA_WIDTH-1:0]   alu_a_out,
   output logic [DATA_WIDTH-1:0]   alu_b_out,
   input  logic [DATA_WIDTH:0]     alu_result_in,
   output logic                    busy_out,
   output logic                    grant_id_out
);

   // state | meaning
   // IDLE  | waiting for a request; req_ready_out asserted toward the selected requester
   // EXEC  | ALU inputs registered; result captured at the next edge
   // RESP  | result presented to the granted requester until it is consumed
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic                    grant_q, grant_d;
   logic [OPCODE_WIDTH-1:0] alu_op_q, alu_op_d;
   logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
   logic [DATA_WIDTH:0]     resp_data_q, resp_data_d;
   logic [1:0]              resp_valid_q, resp_valid_d;
   logic                    sel;

   // Requester 1 wins if it is alone, or if both are valid and requester 0 was last served
   assign sel = req_valid_in[1] & (~req_valid_in[0] | ~last_grant_q);

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_d       = grant_q;
      alu_op_d      = alu_op_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      resp_data_d   = resp_data_q;
      resp_valid_d  = resp_valid_q;
      req_ready_out = 2'b00;
      case (state_q)
         IDLE: begin
            if (|req_valid_in) begin
               req_ready_out = sel ? 2'b10 : 2'b01;
               grant_d       = sel;
               alu_op_d      = sel ? req1_opcode_in : req0_opcode_in;
               alu_a_d       = sel ? req1_a_in : req0_a_in;
               alu_b_d       = sel ? req1_b_in : req0_b_in;
               state_d       = EXEC;
            end
         end
         EXEC: begin
            resp_data_d  = alu_result_in;
            resp_valid_d = grant_q ? 2'b10 : 2'b01;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready_in[grant_q]) begin
               last_grant_d = grant_q;
               resp_valid_d = 2'b00;
               state_d      = IDLE;
            end
         end
         default: begin
            resp_valid_d = 2'b00;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign resp_valid_out = resp_valid_q;
   assign resp_data_out  = resp_data_q;
   assign alu_opcode_out = alu_op_q;
   assign alu_a_out      = alu_a_q;
   assign alu_b_out      = alu_b_q;
   assign grant_id_out   = grant_q;
   assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small attached ALU model.
// Vector table for single commands, hand sequences for arbitration, stalls and reset.
module tb_alu_share_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [1:0] req_valid_in, req_ready_out, resp_valid_out, resp_ready_in;
   logic [3:0] req0_opcode_in, req1_opcode_in, alu_opcode_out;
   logic [7:0] req0_a_in, req0_b_in, req1_a_in, req1_b_in, alu_a_out, alu_b_out;
   logic [8:0] resp_data_out, alu_result_in;
   logic       busy_out, grant_id_out;

   int n_vec  = 0;
   int n_fail = 0;

   alu_share_arbiter #(.DATA_WIDTH(8), .OPCODE_WIDTH(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req0_opcode_in(req0_opcode_in), .req0_a_in(req0_a_in), .req0_b_in(req0_b_in),
      .req1_opcode_in(req1_opcode_in), .req1_a_in(req1_a_in), .req1_b_in(req1_b_in),
      .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
      .resp_data_out(resp_data_out),
      .alu_opcode_out(alu_opcode_out), .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
      .alu_result_in(alu_result_in),
      .busy_out(busy_out), .grant_id_out(grant_id_out)
   );

   always #5 clk_in = ~clk_in;

   always_comb begin
      case (alu_opcode_out)
         OP_ADD:  alu_result_in = {1'b0, alu_a_out} + {1'b0, alu_b_out};
         OP_SUB:  alu_result_in = {1'b0, alu_a_out} - {1'b0, alu_b_out};
         OP_AND:  alu_result_in = {1'b0, alu_a_out & alu_b_out};
         OP_OR:   alu_result_in = {1'b0, alu_a_out | alu_b_out};
         OP_XOR:  alu_result_in = {1'b0, alu_a_out ^ alu_b_out};
         default: alu_result_in = 9'h000;
      endcase
   end

   typedef struct {
      logic       req;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input logic req, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b);
      if (req) begin
         req1_opcode_in = op; req1_a_in = a; req1_b_in = b;
      end else begin
         req0_opcode_in = op; req0_a_in = a; req0_b_in = b;
      end
   endtask

   // Full single command: accept, check ALU drive, check response, consume.
   task automatic run_cmd(input logic req, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [8:0] exp);
      logic [1:0] onehot;
      int         n;
      onehot = req ? 2'b10 : 2'b01;
      set_req(req, op, a, b);
      req_valid_in = onehot;
      #1;
      n = 0;
      while (req_ready_out !== onehot && n < 10) begin
         step();
         n++;
      end
      check("cmd_ready", {7'd0, req_ready_out}, {7'd0, onehot});
      step();
      req_valid_in = 2'b00;
      check("cmd_alu_op", {5'd0, alu_opcode_out}, {5'd0, op});
      check("cmd_alu_a", {1'b0, alu_a_out}, {1'b0, a});
      check("cmd_alu_b", {1'b0, alu_b_out}, {1'b0, b});
      check("cmd_grant", {8'd0, grant_id_out}, {8'd0, req});
      check("cmd_exec_noresp", {7'd0, resp_valid_out}, 9'd0);
      step();
      check("cmd_resp_valid", {7'd0, resp_valid_out}, {7'd0, onehot});
      check("cmd_resp_data", resp_data_out, exp);
      resp_ready_in = onehot;
      step();
      resp_ready_in = 2'b00;
      check("cmd_resp_clear", {7'd0, resp_valid_out}, 9'd0);
      check("cmd_idle", {8'd0, busy_out}, 9'd0);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, OP_ADD, 8'hFF, 8'h01, 9'h100};
      vecs[1] = '{1'b1, OP_SUB, 8'h00, 8'h01, 9'h1FF};
      vecs[2] = '{1'b0, OP_ADD, 8'h12, 8'h34, 9'h046};
      vecs[3] = '{1'b1, OP_SUB, 8'h80, 8'h7F, 9'h001};
      vecs[4] = '{1'b0, OP_AND, 8'hF0, 8'h3C, 9'h030};
      vecs[5] = '{1'b1, OP_OR,  8'hA0, 8'h05, 9'h0A5};
      vecs[6] = '{1'b0, OP_XOR, 8'hFF, 8'h0F, 9'h0F0};
      vecs[7] = '{1'b1, OP_ADD, 8'h80, 8'h80, 9'h100};

      rst_in = 1'b1;
      req_valid_in = 2'b11;
      resp_ready_in = 2'b00;
      set_req(1'b0, OP_ADD, 8'h01, 8'h02);
      set_req(1'b1, OP_ADD, 8'h03, 8'h04);

      // Reset with both requesters valid: requester 0 wins the first tie
      step();
      step();
      check("rst_resp_valid", {7'd0, resp_valid_out}, 9'd0);
      check("rst_busy", {8'd0, busy_out}, 9'd0);
      check("rst_alu_a", {1'b0, alu_a_out}, 9'd0);
      check("rst_resp_data", resp_data_out, 9'd0);
      rst_in = 1'b0;
      #1;
      check("rst_first_ready", {7'd0, req_ready_out}, 9'b01);
      step();
      req_valid_in = 2'b00;
      check("rst_first_grant", {8'd0, grant_id_out}, 9'd0);
      check("rst_first_busy", {8'd0, busy_out}, 9'd1);
      step();
      check("rst_first_resp", {7'd0, resp_valid_out}, 9'b01);
      check("rst_first_data", resp_data_out, 9'h003);
      resp_ready_in = 2'b01;
      step();
      resp_ready_in = 2'b00;

      for (int i = 0; i < 8; i++)
         run_cmd(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Both valid continuously: strict alternation at a 3-cycle spacing
      do_reset();
      set_req(1'b0, OP_ADD, 8'h10, 8'h20);
      set_req(1'b1, OP_SUB, 8'h50, 8'h08);
      req_valid_in = 2'b11;
      resp_ready_in = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("rr_ready", {7'd0, req_ready_out}, (k % 2 == 0) ? 9'b01 : 9'b10);
         step();
         check("rr_grant", {8'd0, grant_id_out}, (k % 2 == 0) ? 9'd0 : 9'd1);
         check("rr_exec_ready", {7'd0, req_ready_out}, 9'd0);
         step();
         check("rr_resp_valid", {7'd0, resp_valid_out}, (k % 2 == 0) ? 9'b01 : 9'b10);
         check("rr_resp_data", resp_data_out, (k % 2 == 0) ? 9'h030 : 9'h048);
         step();
      end
      req_valid_in = 2'b00;
      resp_ready_in = 2'b00;
      step();

      // Stalled response for requester 1; requester 0 blocked, wrong-bit ready ignored
      set_req(1'b1, OP_SUB, 8'h00, 8'h01);
      req_valid_in = 2'b10;
      #1;
      check("stall_ready", {7'd0, req_ready_out}, 9'b10);
      step();
      req_valid_in = 2'b01;
      step();
      resp_ready_in = 2'b01;
      for (int k = 0; k < 5; k++) begin
         check("stall_valid", {7'd0, resp_valid_out}, 9'b10);
         check("stall_data", resp_data_out, 9'h1FF);
         check("stall_req_ready", {7'd0, req_ready_out}, 9'd0);
         step();
      end
      req_valid_in = 2'b00;
      resp_ready_in = 2'b10;
      step();
      resp_ready_in = 2'b00;
      check("stall_release_valid", {7'd0, resp_valid_out}, 9'd0);
      check("stall_release_idle", {8'd0, busy_out}, 9'd0);

      // Reset during EXEC discards the command and restores last_grant=1
      run_cmd(1'b0, OP_ADD, 8'h01, 8'h01, 9'h002);
      set_req(1'b1, OP_ADD, 8'h22, 8'h11);
      req_valid_in = 2'b10;
      step();
      req_valid_in = 2'b00;
      check("rexec_busy_before", {8'd0, busy_out}, 9'd1);
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      check("rexec_busy", {8'd0, busy_out}, 9'd0);
      check("rexec_grant", {8'd0, grant_id_out}, 9'd0);
      for (int k = 0; k < 3; k++) begin
         check("rexec_no_resp", {7'd0, resp_valid_out}, 9'd0);
         step();
      end
      req_valid_in = 2'b11;
      #1;
      check("rexec_tie_ready", {7'd0, req_ready_out}, 9'b01);
      req_valid_in = 2'b00;
      run_cmd(1'b1, OP_SUB, 8'h40, 8'h01, 9'h03F);

      // Requester 0 pulses valid for one cycle while a response is pending
      set_req(1'b1, OP_ADD, 8'h05, 8'h06);
      req_valid_in = 2'b10;
      step();
      req_valid_in = 2'b00;
      step();
      set_req(1'b0, OP_XOR, 8'hAA, 8'h55);
      req_valid_in = 2'b01;
      #1;
      check("pulse_ready", {7'd0, req_ready_out}, 9'd0);
      step();
      req_valid_in = 2'b00;
      check("pulse_data", resp_data_out, 9'h00B);
      resp_ready_in = 2'b10;
      step();
      resp_ready_in = 2'b00;
      for (int k = 0; k < 3; k++) begin
         check("pulse_no_resp", {7'd0, resp_valid_out}, 9'd0);
         check("pulse_idle", {8'd0, busy_out}, 9'd0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
